// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, ALU op
// codes, operand/PC mux selects and the control FSM state encoding.
package multicycle_control_pkg;

    // Instruction opcodes (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    // alu_op codes understood by the ALU control decoder
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_RTYPE = 3'b010;
    localparam logic [2:0] ALU_ADDI  = 3'b011;
    localparam logic [2:0] ALU_ORI   = 3'b100;
    localparam logic [2:0] ALU_ANDI  = 3'b101;
    localparam logic [2:0] ALU_SLTI  = 3'b110;

    // ALU operand B select
    localparam logic [1:0] SRC_B_REG     = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    // Next-PC select
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_EXEC_I   = 4'd10,
        S_I_WB     = 4'd11
    } state_t;

    // Immediate-operand ALU instructions handled by EXEC_I / I_WB
    function automatic logic is_itype(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_ANDI) ||
               (op == OP_ORI)  || (op == OP_SLTI);
    endfunction

    // Any opcode this controller knows how to sequence
    function automatic logic is_known_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J)  || is_itype(op);
    endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational Moore decode: maps the current control state (plus opcode
// and mem_ready where a state depends on them) onto datapath controls.
module control_decode
    import multicycle_control_pkg::*;
(
    input  state_t      state,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        mem_to_reg,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  pc_source,
    output logic [2:0]  alu_op,
    output logic        instr_done
);

    // Per-state control values; everything not named for a state stays 0
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRC_B_REG;
        pc_source     = PC_SRC_ALU;
        alu_op        = ALU_ADD;
        instr_done    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRC_B_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = SRC_B_IMM_SH2;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_RTYPE;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PC_SRC_ALUOUT;
                instr_done    = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PC_SRC_JUMP;
                instr_done = 1'b1;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
                case (opcode)
                    OP_ADDI: alu_op = ALU_ADDI;
                    OP_ANDI: alu_op = ALU_ANDI;
                    OP_ORI:  alu_op = ALU_ORI;
                    OP_SLTI: alu_op = ALU_SLTI;
                    default: alu_op = ALU_ADD;
                endcase
            end
            S_I_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath: state register,
// next-state sequencing, sticky illegal-opcode flag and retire counter.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_source,
    output logic [2:0]       alu_op,
    output logic [3:0]       state,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_t           state_q;
    state_t           state_d;
    logic             illegal_q;
    logic [CNT_W-1:0] retired_q;

    logic pc_write_dec;
    logic pc_write_cond_dec;
    logic ir_write_dec;
    logic reg_write_dec;
    logic mem_write_dec;
    logic instr_done_dec;
    logic unused_zero;

    // The branch decision is taken in the datapath through pc_write_cond
    assign unused_zero = zero;

    control_decode u_decode (
        .state         (state_q),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write_dec),
        .pc_write_cond (pc_write_cond_dec),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write_dec),
        .ir_write      (ir_write_dec),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write_dec),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .pc_source     (pc_source),
        .alu_op        (alu_op),
        .instr_done    (instr_done_dec)
    );

    // Write enables and the retire pulse are held off while reset is asserted
    assign pc_write      = pc_write_dec      & ~rst;
    assign pc_write_cond = pc_write_cond_dec & ~rst;
    assign ir_write      = ir_write_dec      & ~rst;
    assign reg_write     = reg_write_dec     & ~rst;
    assign mem_write     = mem_write_dec     & ~rst;
    assign instr_done    = instr_done_dec    & ~rst;

    assign state   = state_q;
    assign illegal = illegal_q;
    assign retired = retired_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Next-state sequencing; memory states hold until mem_ready
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if ((opcode == OP_LW) || (opcode == OP_SW)) state_d = S_MEM_ADDR;
                else if (opcode == OP_RTYPE)                state_d = S_EXEC_R;
                else if (opcode == OP_BEQ)                  state_d = S_BRANCH;
                else if (opcode == OP_J)                    state_d = S_JUMP;
                else if (is_itype(opcode))                  state_d = S_EXEC_I;
                else                                        state_d = S_FETCH;
            end
            S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   state_d = mem_ready ? S_FETCH : S_MEM_WR;
            S_EXEC_R:   state_d = S_R_WB;
            S_R_WB:     state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_EXEC_I:   state_d = S_I_WB;
            S_I_WB:     state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Sticky flag for an opcode this controller cannot sequence
    always_ff @(posedge clk) begin
        if (rst)
            illegal_q <= 1'b0;
        else if ((state_q == S_DECODE) && !is_known_op(opcode))
            illegal_q <= 1'b1;
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk) begin
        if (rst)
            retired_q <= '0;
        else if (instr_done_dec)
            retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control against a path-based reference
// model: each opcode maps to its list of states, stalls repeat a state.
module tb_multicycle_control;

    localparam int CNT_W = 32;
    localparam int NCYC  = 3000;

    logic             clk = 1'b0;
    logic             rst;
    logic [5:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
    logic             ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]       alu_src_b, pc_source;
    logic [2:0]       alu_op;
    logic [3:0]       state;
    logic             instr_done, illegal;
    logic [CNT_W-1:0] retired;

    int n_checks = 0;
    int n_errors = 0;

    multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
        .alu_op(alu_op), .state(state), .instr_done(instr_done),
        .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Number of cycles an opcode takes with memory always ready
    function automatic int path_len(input logic [5:0] op);
        case (op)
            6'b100011: return 5;
            6'b101011, 6'b000000, 6'b001000, 6'b001100, 6'b001101, 6'b001010: return 4;
            6'b000100, 6'b000010: return 3;
            default: return 2;
        endcase
    endfunction

    // State visited at step idx of an opcode's instruction
    function automatic int path_state(input logic [5:0] op, input int idx);
        int p[5];
        p = '{0, 1, 0, 0, 0};
        case (op)
            6'b100011: p = '{0, 1, 2, 3, 4};
            6'b101011: p = '{0, 1, 2, 5, 0};
            6'b000000: p = '{0, 1, 6, 7, 0};
            6'b001000, 6'b001100, 6'b001101, 6'b001010: p = '{0, 1, 10, 11, 0};
            6'b000100: p = '{0, 1, 8, 0, 0};
            6'b000010: p = '{0, 1, 9, 0, 0};
            default:   p = '{0, 1, 0, 0, 0};
        endcase
        return p[idx];
    endfunction

    function automatic bit known(input logic [5:0] op);
        return path_len(op) != 2;
    endfunction

    // Expected control word from the per-state output table:
    // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
    //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source, alu_op}
    function automatic logic [16:0] exp_ctl(input int st, input logic [5:0] op,
                                            input logic mr, input logic r);
        logic pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, sa;
        logic [1:0] sb, ps;
        logic [2:0] ao;
        {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, sa} = '0;
        sb = 2'b00; ps = 2'b00; ao = 3'b000;
        case (st)
            0:  begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
            1:  sb = 2'b11;
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin mrd = 1; iod = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iod = 1; end
            6:  begin sa = 1; ao = 3'b010; end
            7:  begin rw = 1; rd = 1; end
            8:  begin sa = 1; ao = 3'b001; pwc = 1; ps = 2'b01; end
            9:  begin pw = 1; ps = 2'b10; end
            10: begin
                sa = 1; sb = 2'b10;
                ao = (op == 6'b001000) ? 3'b011 : (op == 6'b001100) ? 3'b101 :
                     (op == 6'b001101) ? 3'b100 : 3'b110;
            end
            11: rw = 1;
            default: ;
        endcase
        if (r) begin
            pw = 0; pwc = 0; irw = 0; rw = 0; mwr = 0;
        end
        return {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, sa, sb, ps, ao};
    endfunction

    function automatic logic [5:0] pick_opcode();
        logic [5:0] ops[9];
        int r;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                6'b001000, 6'b001100, 6'b001101, 6'b001010};
        r = $urandom_range(0, 10);
        if (r < 9) return ops[r];
        return 6'($urandom_range(0, 63));
    endfunction

    int               m_idx;
    int               m_state;
    logic [CNT_W-1:0] m_retired;
    logic             m_illegal;
    bit               stall, last, m_done;
    int               n_resets_mid;
    int               n_illegal_seen;

    initial begin
        rst       = 1'b1;
        opcode    = 6'b000000;
        zero      = 1'b0;
        mem_ready = 1'b1;
        m_idx     = 0;
        m_retired = '0;
        m_illegal = 1'b0;
        n_resets_mid   = 0;
        n_illegal_seen = 0;
        @(posedge clk);

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            m_state = path_state(opcode, m_idx);
            if (cyc < 3)
                rst = 1'b1;
            else
                rst = (m_state == 3) && ($urandom_range(0, 3) == 0);
            if (rst && cyc >= 3) n_resets_mid++;
            if (m_idx == 0) opcode = pick_opcode();
            zero      = 1'($urandom_range(0, 1));
            mem_ready = ($urandom_range(0, 2) != 0);
            m_state = path_state(opcode, m_idx);
            #1;

            stall  = ((m_state == 0) || (m_state == 3) || (m_state == 5)) && !mem_ready;
            last   = (m_idx == path_len(opcode) - 1);
            m_done = last && known(opcode) && !stall && !rst;

            check("state",   64'(state),   64'(m_state));
            check("ctl",     64'({pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                                  ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                                  alu_src_b, pc_source, alu_op}),
                             64'(exp_ctl(m_state, opcode, mem_ready, rst)));
            check("done",    64'(instr_done), 64'(m_done));
            check("retired", 64'(retired),    64'(m_retired));
            check("illegal", 64'(illegal),    64'(m_illegal));

            // Advance the model to the state after this clock edge
            if (rst) begin
                m_idx     = 0;
                m_retired = '0;
                m_illegal = 1'b0;
            end else begin
                if (m_state == 1 && !known(opcode)) begin
                    m_illegal = 1'b1;
                    n_illegal_seen++;
                end
                if (m_done) m_retired = m_retired + 1;
                if (!stall) m_idx = last ? 0 : m_idx + 1;
            end
        end

        check("mid_reset_seen", 64'(n_resets_mid > 0),   64'd1);
        check("illegal_seen",   64'(n_illegal_seen > 0), 64'd1);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control state machine for the multi-cycle MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and write-back, driving the datapath mux selects and write enables. It also supplies the 3-bit `alu_op` consumed by the existing ALU control decoder. Sits between the instruction register's opcode field and the datapath; memory accesses stall on a ready handshake.

## Interface
Parameters:
- `CNT_W`, 32, width of retired-instruction counter

Ports:
- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `opcode`  in  6  instruction[31:26] from IR; stable after FETCH
- `zero`  in  1  ALU zero flag (branch condition is qualified in the datapath via `pc_write_cond`)
- `mem_ready`  in  1  memory completes the current read/write this cycle
- `pc_write`, `pc_write_cond`, `i_or_d`, `mem_read`, `mem_write`, `ir_write`, `mem_to_reg`, `reg_dst`, `reg_write`, `alu_src_a`  out  1 each  datapath controls
- `alu_src_b`  out  2  00 regB, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- `pc_source`  out  2  00 ALU result, 01 ALUOut, 10 jump target
- `alu_op`  out  3  000 add, 001 sub, 010 R-type, 011 addi, 100 ori, 101 andi, 110 slti
- `state`  out  4  current state, for debug
- `instr_done`  out  1  one-cycle pulse in an instruction's last cycle
- `illegal`  out  1  sticky flag: unknown opcode decoded
- `retired`  out  CNT_W  count of completed instructions

## Operation
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000, andi 001100, ori 001101, slti 001010.
- States (encoding): FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC_R 6, R_WB 7, BRANCH 8, JUMP 9, EXEC_I 10, I_WB 11; codes 12–15 unused and go to FETCH.
- Moore outputs; any control not listed for a state is 0:
  - FETCH: `mem_read`=1, `alu_src_b`=01, `alu_op`=000; `ir_write`=`pc_write`=`mem_ready`; stay until `mem_ready`, then DECODE.
  - DECODE: `alu_src_b`=11, `alu_op`=000. Next state by opcode: lw/sw→MEM_ADDR, R→EXEC_R, beq→BRANCH, j→JUMP, I-type→EXEC_I. Unknown opcode→FETCH, set `illegal`, no `instr_done`.
  - MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=000. Next state: lw→MEM_RD, sw→MEM_WR.
  - MEM_RD: `mem_read`=1, `i_or_d`=1; wait for `mem_ready`, then MEM_WB.
  - MEM_WB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0; then FETCH.
  - MEM_WR: `mem_write`=1, `i_or_d`=1; wait for `mem_ready`, then FETCH.
  - EXEC_R: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=010; then R_WB.
  - R_WB: `reg_write`=1, `reg_dst`=1; then FETCH.
  - BRANCH: `alu_src_a`=1, `alu_op`=001, `pc_write_cond`=1, `pc_source`=01; then FETCH.
  - JUMP: `pc_write`=1, `pc_source`=10; then FETCH.
  - EXEC_I: `alu_src_a`=1, `alu_src_b`=10, `alu_op` by opcode (addi 011, andi 101, ori 100, slti 110); then I_WB.
  - I_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0; then FETCH.
- `instr_done` is high in MEM_WB, R_WB, I_WB, BRANCH, JUMP, and in MEM_WR when `mem_ready`=1.
- `retired` increments on each `instr_done` and wraps modulo 2^CNT_W.
- `illegal` clears only on reset.

## Timing
- Cycle counts with `mem_ready` tied to 1: lw 5, sw 4, R 4, I-type 4, beq 3, j 3.
- Each extra cycle of `mem_ready`=0 in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- Outputs are combinational from `state` (plus `mem_ready` where noted); `state`, `illegal` and `retired` are registered.
- Reset: `state`=FETCH, `retired`=0, `illegal`=0. While `rst`=1, all write enables are forced to 0: `pc_write`, `pc_write_cond`, `ir_write`, `reg_write`, `mem_write`.
- Reset asserted mid-instruction aborts the instruction without retiring it. FETCH begins on the first cycle after `rst` falls.
- `mem_ready` asserted outside FETCH, MEM_RD and MEM_WR is ignored.

## Structure
- Shared package/include holds the opcode constants, `alu_op` codes (already used by the ALU control decoder), state encodings and `alu_src_b`/`pc_source` encodings.
- One natural sub-module, `control_decode`: purely combinational mapping of state, opcode and `mem_ready` to the output controls. The top level holds the state register, next-state logic and counters.

## Test plan
- Reset, then lw (opcode 100011) with `mem_ready`=1 → states 0,1,2,3,4; `reg_write`=`mem_to_reg`=1 in state 4; `retired`=1 after 5 cycles.
- sw with `mem_ready` low for 3 cycles in MEM_WR → `mem_write` held for 4 cycles; `instr_done` only in the last of them; total 7 cycles.
- R-type followed by ori → `alu_op` 010 in EXEC_R, then 100 in EXEC_I; `reg_dst`=1 for the R-type, 0 for ori.
- beq and j → 3 cycles each; BRANCH asserts `pc_write_cond`=1 with `pc_source`=01; JUMP asserts `pc_write`=1 with `pc_source`=10.
- Opcode 111111 → DECODE returns to FETCH; `illegal`=1 and stays set; `retired` unchanged.
- `rst` asserted in MEM_RD → next state FETCH, `retired`=0, no write enables asserted during reset.
